// File: rtl/demux_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// demux_rr_sched_pkg : shared constants/types for the round-robin demux stage
// Rev 1.0
// ============================================================================
package demux_rr_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  function automatic ch_mask_t sel_onehot(input sel_t s);
    ch_mask_t m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_rr_sched_if.sv
`default_nettype none
// ============================================================================
// demux_rr_sched_if : producer-side and consumer-side bundle of the demux stage
// Rev 1.0
// ============================================================================
interface demux_rr_sched_if
  import demux_rr_sched_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  ch_mask_t          ch_en;
  ch_mask_t          out_ready;
  ch_mask_t          out_valid;
  logic [DATA_W-1:0] out_data;
  sel_t              sel;

  // Environment side: producer plus the four consumers.
  modport master (
    output in_valid, in_data, ch_en, out_ready,
    input  in_ready, out_valid, out_data, sel
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, ch_en, out_ready,
    output in_ready, out_valid, out_data, sel
  );

endinterface
`default_nettype wire

// File: rtl/demux_rr_sched_rr_pick4.sv
`default_nettype none
// ============================================================================
// rr_pick4 : combinational 4-way round-robin pick starting at ptr_i
// Rev 1.0
// ============================================================================
module rr_pick4
  import demux_rr_sched_pkg::*;
(
  input  wire ch_mask_t ch_en_i,
  input  wire sel_t     ptr_i,
  output sel_t          next_ch_o,
  output logic          any_en_o
);

  sel_t w_idx;

  assign any_en_o = |ch_en_i;

  // Scan farthest offset first so the nearest enabled channel wins.
  always_comb begin
    next_ch_o = ptr_i;
    w_idx     = ptr_i;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = ptr_i + sel_t'(i);
      if (ch_en_i[w_idx]) begin
        next_ch_o = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_rr_sched.sv
`default_nettype none
// ============================================================================
// demux_rr_sched : one-beat buffer that hands each beat to the next enabled
//                  channel in round-robin order. Rev 1.0
// ============================================================================
module demux_rr_sched
  import demux_rr_sched_pkg::*;
#(
  parameter int DATA_W = 1
)(
  input  wire               clk,
  input  wire               rst_n,
  demux_rr_sched_if.slave   bus
);

  logic [0:0]        state_q, state_d;
  sel_t              sel_q,   sel_d;
  sel_t              ptr_q,   ptr_d;
  logic [DATA_W-1:0] data_q,  data_d;

  sel_t w_next_ch;
  logic w_any_en;
  logic w_full;
  logic w_drain;
  logic w_accept;

  rr_pick4 u_pick (
    .ch_en_i   (bus.ch_en),
    .ptr_i     (ptr_q),
    .next_ch_o (w_next_ch),
    .any_en_o  (w_any_en)
  );

  assign w_full       = (state_q == ST_FULL);
  // Only the owning channel's ready matters; the held beat ignores later mask changes.
  assign w_drain      = w_full & bus.out_ready[sel_q];
  assign bus.in_ready = w_any_en & (~w_full | w_drain);
  assign w_accept     = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    if (w_accept) begin
      state_d = ST_FULL;
      sel_d   = w_next_ch;
      ptr_d   = w_next_ch + sel_t'(1);
      data_d  = bus.in_data;
    end else if (w_drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = w_full ? sel_onehot(sel_q) : '0;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_demux_rr_sched : directed self-checking bench for demux_rr_sched
// Rev 1.0
// ============================================================================
module tb_demux_rr_sched;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  demux_rr_sched_if #(.DATA_W(1)) bus ();

  demux_rr_sched #(.DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after the rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_data;
  logic [1:0] skip_sel [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rot_data = 4'b1100;
    skip_sel = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};

    // Reset and idle
    rst_n         = 1'b0;
    bus.ch_en     = 4'b1111;
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 4'b0000;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_sel",       32'(bus.sel),       32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
      chk("idle_sel",       32'(bus.sel),       32'h0);
    end

    // Full rotation, back-to-back beats 0,0,1,1
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = rot_data[i];
      #1;
      chk("rot_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("rot_sel",       32'(bus.sel),       32'(i));
      chk("rot_out_valid", 32'(bus.out_valid), 32'(4'b0001 << i));
      chk("rot_out_data",  32'(bus.out_data),  32'(rot_data[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rot_drained", 32'(bus.out_valid), 32'h0);

    // Skip disabled channels (ptr restarts at 0)
    bus.ch_en    = 4'b1010;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 1'(i);
      tick();
      chk("skip_sel",       32'(bus.sel),       32'(skip_sel[i]));
      chk("skip_out_valid", 32'(bus.out_valid), 32'(4'b0001 << skip_sel[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("skip_drained", 32'(bus.out_valid), 32'h0);

    // Backpressure: beat to ch0 held, then second beat accepted on drain edge
    bus.ch_en     = 4'b0001;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    tick();
    chk("bp_sel", 32'(bus.sel), 32'h0);
    bus.ch_en   = 4'b1111;
    bus.in_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_out_data",  32'(bus.out_data),  32'h1);
    end
    bus.out_ready = 4'b0001;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp2_sel",       32'(bus.sel),       32'h1);
    chk("bp2_out_valid", 32'(bus.out_valid), 32'h2);
    chk("bp2_out_data",  32'(bus.out_data),  32'h0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0010;
    tick();
    chk("bp2_drained", 32'(bus.out_valid), 32'h0);

    // Mask change while FULL (ptr now 2)
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    tick();
    chk("mask_sel", 32'(bus.sel), 32'h2);
    bus.in_valid  = 1'b0;
    bus.ch_en     = 4'b0001;
    bus.out_ready = 4'b1011;
    #1;
    chk("mask_in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mask_hold_valid", 32'(bus.out_valid), 32'h4);
    end
    bus.out_ready = 4'b0100;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b0;
    #1;
    chk("mask_drain_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("mask_next_sel",   32'(bus.sel),       32'h0);
    chk("mask_next_valid", 32'(bus.out_valid), 32'h1);

    // Empty mask: nothing accepted but the held beat still drains
    bus.ch_en     = 4'b0000;
    bus.out_ready = 4'b0001;
    #1;
    chk("noen_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("noen_drained", 32'(bus.out_valid), 32'h0);
    tick();
    chk("noen_no_accept", 32'(bus.out_valid), 32'h0);

    // Async reset mid-stream (ptr now 1)
    bus.ch_en     = 4'b1111;
    bus.out_ready = 4'b0000;
    bus.in_data   = 1'b1;
    tick();
    chk("arst_pre_valid", 32'(bus.out_valid), 32'h2);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_data",  32'(bus.out_data),  32'h0);
    chk("arst_sel",       32'(bus.sel),       32'h0);
    #2;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b1111;
    tick();
    chk("arst_first_sel",   32'(bus.sel),       32'h0);
    chk("arst_first_valid", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler and output stage for the 1-to-4 demultiplexer datapath. It accepts a stream of data beats on a single valid/ready input and registers each beat. It chooses the destination channel by rotating over the enabled channels, drives the select code, and raises exactly one `out_valid` bit until that channel accepts. It sits between a single producer and four consumers and replaces hand-driven `Sel` sequencing.

## Interface
- `DATA_W`, default 1: beat width in bits.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `in_valid`  in  1: producer has a beat.
- `in_ready`  out  1: block accepts the beat this cycle.
- `in_data`  in  DATA_W: beat payload.
- `ch_en`  in  4: per-channel enable mask; a channel with a 0 is skipped.
- `out_ready`  in  4: per-channel consumer ready.
- `out_valid`  out  4: one-hot valid for the held beat; all zeros when empty.
- `out_data`  out  DATA_W: held beat. It is broadcast to all four channels and qualified by `out_valid`.
- `sel`  out  2: index of the channel owning the held beat.

## Operation
- The FSM has two states:
  - EMPTY: no beat is held.
  - FULL: one beat is held for channel `sel`.
- Registers:
  - `full`
  - `sel[1:0]`
  - `ptr[1:0]`, the next round-robin start point
  - `out_data`
- Grant: `next_ch` is the first channel with `ch_en` set, searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (all mod 4).
  - `any_en = |ch_en`.
- `drain = full & out_ready[sel]`.
- `in_ready = any_en & (~full | drain)`. This is combinational.
- `accept = in_valid & in_ready`.
- Transitions:
  - EMPTY with accept → FULL. On the same edge: `sel <= next_ch`, `ptr <= next_ch + 1` (wraps 3→0), `out_data <= in_data`.
  - FULL with drain and accept → FULL, with the new beat. `sel` and `ptr` update as above, with no bubble.
  - FULL with drain and no accept → EMPTY. `sel` and `out_data` keep their values.
  - FULL without drain → FULL, and all registers hold.
- `out_valid = full ? (4'b0001 << sel) : 4'b0000`.
- Boundary conditions:
  - `ch_en == 0`: `in_ready` is 0 and no beat is accepted. A beat already held still drains normally.
  - `ch_en` changes while FULL: the held beat stays bound to its `sel`, even if that channel is now disabled. The new mask affects only the next grant.
  - Single enabled channel: every beat goes to that channel, and `ptr` still advances to channel+1.
  - `out_ready` bits for channels other than `sel` are ignored.
  - `rst_n` asserted mid-operation: the held beat is discarded immediately, without waiting for a clock.

## Timing
- Reset values: `full=0`, `sel=0`, `ptr=0`, `out_data=0`. As a result, `out_valid=0` and `in_ready=|ch_en`.
- Latency: a beat accepted at edge k is presented on `out_valid`/`out_data` from edge k until the edge where it drains.
- Throughput: one beat per cycle when consumers are always ready.
- Combinational paths:
  - `out_ready` → `in_ready`
  - `ch_en` → `in_ready`
- There is no combinational path from `in_*` to `out_*`.
- Producer rules: `in_valid` must not drop and `in_data` must not change until the beat is accepted. The block does not check this.

## Structure
- A shared package or include holds:
  - `ST_EMPTY` and `ST_FULL` encodings
  - `NUM_CH = 4`
  - `SEL_W = 2`
- The natural sub-module is `rr_pick4`. It is combinational: given `ch_en` and `ptr`, it outputs `next_ch` and `any_en`. It is reusable by other 4-way schedulers.
- The top level contains:
  - the FSM
  - the registers
  - `out_valid` decode

## Test plan
- Reset and idle:
  - Drive `rst_n=0` with `ch_en=4'b1111` → `out_valid=0`, `sel=0`, `out_data=0`, `in_ready=1`.
  - Release reset and hold `in_valid=0` for 5 cycles → no change.
- Full rotation:
  - Stimulus: `ch_en=4'b1111`, `out_ready=4'b1111`, `DATA_W=1`, four back-to-back beats `0,0,1,1`.
  - Required: `sel` = 0,1,2,3 on consecutive cycles, and `out_valid` = 0001, 0010, 0100, 1000.
  - Required: `out_data` follows the beats, and `in_ready` stays 1 throughout.
- Skip disabled channels:
  - Stimulus: `ch_en=4'b1010`, five beats.
  - Required: `sel` = 1,3,1,3,1, with `out_valid` never 0001 or 0100.
- Backpressure:
  - Stimulus: one beat to ch0 with `out_ready=4'b0000` for 3 cycles → `in_ready=0`, `out_valid=0001` held, `out_data` stable.
  - Raise `out_ready[0]` with a second beat pending → second beat accepted on the same edge, `sel=1` with no idle cycle.
- Mask change while FULL:
  - Stimulus: hold a beat for ch2, then set `ch_en=4'b0001`.
  - Required: `out_valid=0100` persists until `out_ready[2]`. The next beat goes to ch0.
- Async reset mid-stream:
  - Stimulus: assert `rst_n` low between clock edges while FULL.
  - Required: `out_valid=0` within that cycle, with no clock edge needed. After release, the first beat goes to ch0.
